// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit 7-segment scan multiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seg7_pkg;

  // Scan slots in display order; the FSM walks them strictly in this cycle.
  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } scan_state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low anode patterns; an[0] is units, an[1] is tens.
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment glyph; non-BCD codes show a dash.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Glyph lookup; codes 10-15 light only segment g.
  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed two-digit 7-segment driver with ghost gaps and overflow blink.
// Latency: inputs reach the display at the next frame boundary (en after one clock).
// Backpressure: none; free-running scan, inputs are sampled, never stalled.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int GAP_CYCLES   = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q0,
  input  logic [3:0] q1,
  input  logic       c,
  input  logic       en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       ovf
);

  localparam int DWELL_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int DW        = $clog2(DWELL_MAX);
  localparam int BW        = $clog2(BLINK_FRAMES + 1);

  localparam logic [DW-1:0] SHOW_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LD  = BW'(BLINK_FRAMES);

  scan_state_t   state;
  scan_state_t   state_nxt;
  logic [DW-1:0] dwell;
  logic          slot_done;
  logic          frame_wrap;
  logic [3:0]    s0;
  logic [3:0]    s1;
  logic          en_r;
  logic          c_r;
  logic          c_d;
  logic          carry_edge;
  logic [BW-1:0] blink_cnt;
  logic [3:0]    digit;
  logic [6:0]    glyph;

  // Slot ends when the shared dwell counter reaches the slot's last cycle.
  always_comb begin
    slot_done = 1'b0;
    unique case (state)
      SHOW0, SHOW1: slot_done = (dwell == SHOW_LAST);
      default:      slot_done = (dwell == GAP_LAST);
    endcase
  end

  assign frame_wrap = (state == GAP1) && slot_done;
  assign carry_edge = c_r & ~c_d;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SHOW0;
    else        state <= state_nxt;
  end

  // Next-state: fixed ring SHOW0 -> GAP0 -> SHOW1 -> GAP1.
  always_comb begin
    state_nxt = state;
    if (slot_done) begin
      unique case (state)
        SHOW0:   state_nxt = GAP0;
        GAP0:    state_nxt = SHOW1;
        SHOW1:   state_nxt = GAP1;
        default: state_nxt = SHOW0;
      endcase
    end
  end

  // Dwell counter restarts on every slot change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         dwell <= '0;
    else if (slot_done) dwell <= '0;
    else                dwell <= dwell + DW'(1);
  end

  // Shadow digits only move at the frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0 <= 4'd0;
      s1 <= 4'd0;
    end else if (frame_wrap) begin
      s0 <= q0;
      s1 <= q1;
    end
  end

  // Register enable and two carry stages; edge detect isolates outputs from c.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r <= 1'b0;
      c_r  <= 1'b0;
      c_d  <= 1'b0;
    end else begin
      en_r <= en;
      c_r  <= c;
      c_d  <= c_r;
    end
  end

  // Overflow frame counter: a carry edge (re)loads, frame boundaries count down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             blink_cnt <= '0;
    else if (carry_edge)                    blink_cnt <= BLINK_LD;
    else if (frame_wrap && blink_cnt != '0) blink_cnt <= blink_cnt - BW'(1);
  end

  assign ovf   = (blink_cnt != '0);
  assign digit = (state == SHOW1) ? s1 : s0;

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (glyph)
  );

  // Output decode: drive one anode in SHOW slots, everything dark otherwise.
  always_comb begin
    an  = AN_OFF;
    seg = SEG_BLANK;
    dp  = 1'b1;
    if (en_r) begin
      unique case (state)
        SHOW0: begin
          an  = AN_UNITS;
          seg = glyph;
          dp  = ~ovf;
        end
        SHOW1: begin
          an  = AN_TENS;
          seg = (s1 == 4'd0) ? SEG_BLANK : glyph;
        end
        default: begin
          an  = AN_OFF;
          seg = SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with a frame-position reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_mux;

  localparam int SD    = 4;
  localparam int GAP   = 1;
  localparam int BF    = 2;
  localparam int FRAME = 2 * (SD + GAP);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q0, q1;
  logic       c, en;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .SCAN_DIV     (SD),
    .GAP_CYCLES   (GAP),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .q0    (q0),
    .q1    (q1),
    .c     (c),
    .en    (en),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .ovf   (ovf)
  );

  // Reference glyph table, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Model: clocks since reset release, sampled digits, enable, carry history, blink frames left.
  int         m_k;
  logic [3:0] m_s0, m_s1;
  logic       m_en;
  logic       m_c1, m_c2;
  int         m_blink;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k = 0; m_s0 = 4'd0; m_s1 = 4'd0; m_en = 1'b0;
      m_c1 = 1'b0; m_c2 = 1'b0; m_blink = 0;
    end else begin
      if (m_c1 && !m_c2)                              m_blink = BF;
      else if ((m_k % FRAME) == FRAME - 1 && m_blink > 0) m_blink = m_blink - 1;
      if ((m_k % FRAME) == FRAME - 1) begin
        m_s0 = q0;
        m_s1 = q1;
      end
      m_c2 = m_c1;
      m_c1 = c;
      m_en = en;
      m_k  = m_k + 1;
    end
  end

  function automatic int pos();
    return m_k % FRAME;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against what the frame position implies.
  task automatic cmp_model();
    logic [1:0] ea;
    logic [6:0] es;
    logic       ed, eo;
    int p;
    p  = pos();
    eo = (m_blink != 0);
    ea = 2'b11; es = 7'h7F; ed = 1'b1;
    if (m_en) begin
      if (p < SD) begin
        ea = 2'b10; es = ref_glyph(m_s0); ed = ~eo;
      end else if (p >= SD + GAP && p < 2 * SD + GAP) begin
        ea = 2'b01; es = (m_s1 == 4'd0) ? 7'h7F : ref_glyph(m_s1);
      end
    end
    check("model{an,seg,dp,ovf}", {5'd0, an, seg, dp, ovf}, {5'd0, ea, es, ed, eo});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic wait_pos(input int lo, input int hi);
    int n;
    n = 0;
    while (!(pos() >= lo && pos() <= hi) && n < 2 * FRAME) begin
      tick(1);
      n++;
    end
    check("wait_pos_reached", {15'd0, (pos() >= lo && pos() <= hi)}, 16'd1);
  endtask

  task automatic carry_pulse();
    c = 1'b1; tick(1);
    c = 1'b0; tick(1);
  endtask

  initial begin
    rst = 1'b0; q0 = 4'd0; q1 = 4'd0; c = 1'b0; en = 1'b0;
    #12;
    check("rst_an",  {14'd0, an},  16'h0003);
    check("rst_seg", {9'd0, seg},  16'h007F);
    check("rst_dp",  {15'd0, dp},  16'h0001);
    check("rst_ovf", {15'd0, ovf}, 16'h0000);
    tick(2);

    // Steady 47: first frame shows shadow 0 (units 0, tens blank).
    rst = 1'b1; q1 = 4'd4; q0 = 4'd7; en = 1'b1;
    tick(1);
    check("first_units_zero", {7'd0, an, seg}, {7'd0, 2'b10, 7'h40});
    tick(3 * FRAME - 1);
    wait_pos(0, SD - 1);
    check("units_7", {7'd0, an, seg}, {7'd0, 2'b10, 7'h78});
    wait_pos(SD + GAP, 2 * SD + GAP - 1);
    check("tens_4", {7'd0, an, seg}, {7'd0, 2'b01, 7'h19});

    // Leading-zero blank on tens.
    q1 = 4'd0; q0 = 4'd5;
    tick(FRAME);
    wait_pos(SD + GAP, 2 * SD + GAP - 1);
    check("tens_blank", {7'd0, an, seg}, {7'd0, 2'b01, 7'h7F});
    tick(FRAME);

    // Invalid BCD shows a dash.
    q1 = 4'd2; q0 = 4'hC;
    tick(FRAME);
    wait_pos(0, SD - 1);
    check("units_dash", {9'd0, seg}, 16'h003F);

    // Change units mid-SHOW1; the glyph must wait for the frame boundary.
    wait_pos(SD + GAP + 1, SD + GAP + 1);
    q0 = 4'd3;
    wait_pos(0, SD - 1);
    check("units_3_after_wrap", {9'd0, seg}, 16'h0030);
    tick(FRAME);

    // Single-clock carry pulse.
    carry_pulse();
    check("ovf_set", {15'd0, ovf}, 16'h0001);
    tick(4 * FRAME);

    // Carry held high for 30 clocks triggers once.
    c = 1'b1; tick(30);
    c = 1'b0; tick(4 * FRAME);

    // Enable drop for 7 clocks.
    wait_pos(1, 1);
    en = 1'b0; tick(1);
    check("en_off_an", {14'd0, an}, 16'h0003);
    tick(6);
    en = 1'b1; tick(2 * FRAME);

    // Reset mid-SHOW1 while overflow is active.
    wait_pos(0, 0);
    carry_pulse();
    wait_pos(SD + GAP, 2 * SD + GAP - 1);
    check("pre_rst_ovf", {15'd0, ovf}, 16'h0001);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_an",  {14'd0, an},  16'h0003);
    check("mid_rst_seg", {9'd0, seg},  16'h007F);
    check("mid_rst_ovf", {15'd0, ovf}, 16'h0000);
    check("mid_rst_dp",  {15'd0, dp},  16'h0001);
    tick(2);
    rst = 1'b1;
    tick(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SCAN_DIV, 1000, clocks each digit is driven per scan slot (>=2).
REQ-002 GAP_CYCLES, 2, clocks of all-anodes-off between slots, for ghosting suppression (>=1).
REQ-003 BLINK_FRAMES, 50, scan frames the overflow indication persists after a carry.
REQ-004 clk  input  1  single system clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 q0  input  4  BCD units digit from the upstream two-digit counter.
REQ-007 q1  input  4  BCD tens digit from the upstream two-digit counter.
REQ-008 c  input  1  carry/wrap flag from the upstream counter (level or pulse).
REQ-009 en  input  1  display enable; low blanks the anodes.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 an  output  2  digit anodes, active-low; an[0] is units, an[1] is tens.
REQ-013 ovf  output  1  high while the overflow indication is active.

Function
REQ-014 FSM states SHOW0, GAP0, SHOW1, GAP1; SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0, never otherwise.
REQ-015 SHOWx lasts exactly SCAN_DIV clocks; GAPx lasts exactly GAP_CYCLES clocks; frame = 2*(SCAN_DIV+GAP_CYCLES) clocks.
REQ-016 One shared dwell counter: cleared on every state change, counts up, with transition at count == duration-1.
REQ-017 Shadow registers s0/s1 load q0/q1 on the GAP1->SHOW0 transition only; this prevents mid-frame tearing.
REQ-018 en is registered once (en_r); the inputs q0, q1, c and en have no combinational path to any output.
REQ-019 SHOW0 with en_r=1: an=2'b10 and seg=decode(s0).
REQ-020 SHOW1 with en_r=1: an=2'b01 and seg=decode(s1), except s1==0 gives seg=7'h7F (leading-zero blank).
REQ-021 GAP0/GAP1, or en_r=0: an=2'b11, seg=7'h7F, dp=1; the FSM and counters keep running.
REQ-022 decode: 0-9 give standard active-low glyphs; 10-15 give a dash (only g lit, seg=7'h3F).
REQ-023 Carry edge is c_r & ~c_d, where c_r and c_d are successive registered copies of c; a held-high c counts once.
REQ-024 On a carry edge, blink_cnt loads BLINK_FRAMES; on each GAP1->SHOW0 transition, blink_cnt decrements if nonzero.
REQ-025 When a load and a decrement coincide, the load wins; a carry edge during the blink retriggers the full count.
REQ-026 ovf = (blink_cnt != 0).
REQ-027 dp=0 only in SHOW0 with en_r=1 and ovf=1; dp=1 otherwise.
REQ-028 All counters wrap-free; dwell counter width = clog2(max(SCAN_DIV,GAP_CYCLES)); blink_cnt width = clog2(BLINK_FRAMES+1).

Reset
REQ-029 reset=0 asynchronously forces:
  - state SHOW0; dwell counter 0;
  - s0=s1=0; blink_cnt=0; c_r=c_d=0; en_r=0.
REQ-030 Consequently during reset: an=2'b11, seg=7'h7F, dp=1, ovf=0.
REQ-031 After reset release, the first SHOW0 slot displays shadow values 0/0.
REQ-032 Live inputs are first loaded at the first GAP1->SHOW0 transition.
REQ-033 Reset asserted mid-slot or mid-blink aborts immediately; there is no residual ovf.

Structure
REQ-034 Shared package seg7_pkg holds:
  - the state enumeration;
  - glyph constants SEG_0..SEG_9, SEG_DASH=7'h3F, SEG_BLANK=7'h7F;
  - AN_OFF=2'b11.
REQ-035 One combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out), instantiated once and fed by a mux of s0/s1.

Verification (SCAN_DIV=4, GAP_CYCLES=1, BLINK_FRAMES=2; frame=10 clocks)
REQ-036 Steady value and scan timing:
  - q1=4, q0=7, en=1, run 3 frames;
  - required: an sequence 10×4, 11×1, 01×4, 11×1 repeating;
  - required: seg=SEG_7 while an=10 and SEG_4 while an=01 (from the second frame).
REQ-037 Leading zero: q1=0, q0=5 -> an=01 slots show seg=7'h7F; an=10 slots show SEG_5.
REQ-038 Invalid BCD and tearing:
  - q0=4'hC -> seg=7'h3F in units slots;
  - q0 changed mid-SHOW1 -> units glyph changes only after the next GAP1.
REQ-039 Carry:
  - 1-clock c pulse -> ovf=1 for exactly 2 frame boundaries, then 0;
  - dp=0 only during an=10 while ovf=1;
  - c held high 30 clocks -> single trigger.
REQ-040 Enable and reset:
  - en=0 for 7 clocks -> an=11 one clock after en falls; slot timing is unshifted on en=1;
  - reset=0 mid-SHOW1 with ovf=1 -> immediately an=11, seg=7'h7F, ovf=0.
